fcache_fill: RTL and testbench
==============================

Name: fcache_fill

Overview:
- Line-fill engine that sits directly upstream of the fetch cache (fcache).
- On a miss request it reads WORDS_PER_LINE consecutive 16-bit words from main memory over a valid/ack handshake.
- It assembles them into one 256-bit line and commits the line to fcache with a single-cycle write pulse on fcache's write/addr/wData inputs.
- Only one fill is in flight at a time.

Parameters:
- WORD_W, 16, memory word width in bits.
- WORDS_PER_LINE, 16, words per cache line; must be a power of two. OFF_W = log2(WORDS_PER_LINE). LINE_W = WORD_W*WORDS_PER_LINE (256).
- ADDR_W, 16, width of word addresses and the fcache line index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  miss request.
- req_ready  out  1  engine idle; request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  missing word address.
- mem_rd  out  1  memory read request, held until ack.
- mem_addr  out  ADDR_W  word address of current read.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  WORD_W  read data.
- fc_write  out  1  to fcache write.
- fc_addr  out  ADDR_W  to fcache addr; line index.
- fc_wdata  out  LINE_W  to fcache wData.
- done  out  1  one-cycle pulse coincident with fc_write.
- crit_valid  out  1  critical word available (macro only, else 0).
- crit_data  out  WORD_W  critical word (macro only, else 0).

Behaviour:
- Reset is asynchronous. In reset:
  - state=IDLE, word counter=0, line buffer=0.
  - mem_rd=0, mem_addr=0, fc_write=0, fc_addr=0, fc_wdata=0, done=0, crit_valid=0, crit_data=0.
  - req_ready=1; it is combinational, (state==IDLE).
- States: IDLE, FETCH, COMMIT.
- IDLE → FETCH on accept. On accept, latch:
  - line_idx = req_addr >> OFF_W, zero-extended to ADDR_W;
  - start offset = 0 (see Optional Feature);
  - counter = 0.
- FETCH:
  - mem_rd=1 and mem_addr = {line_idx[ADDR_W-OFF_W-1:0], offset}, stable until ack.
  - On mem_ack: store mem_rdata at bits [offset*WORD_W +: WORD_W] (word 0 least significant). Then offset = (offset+1) mod WORDS_PER_LINE and counter += 1.
  - mem_rd stays high back-to-back; the next address is presented the cycle after the ack.
  - After the WORDS_PER_LINE-th ack, go to COMMIT with mem_rd=0 that cycle.
  - mem_ack while mem_rd=0 is ignored.
- COMMIT (exactly one cycle): fc_write=1, done=1, fc_addr=line_idx, fc_wdata=line buffer. Then IDLE.
- fc_wdata holds its value after commit until the next commit; fc_addr likewise.
- Latency with zero-wait memory:
  - accept at edge 0;
  - acks at cycles 1..16;
  - COMMIT at cycle 17;
  - req_ready=1 at cycle 18.
- req_valid while busy is not accepted; the requester must hold it.
- Address wrap: the line index uses only the upper ADDR_W-OFF_W bits. The line at req_addr 0xFFF5 reads words 0xFFF0..0xFFFF; no carry out of the address.
- Reset mid-FETCH aborts the fill: no fc_write and the buffer is cleared.
- A stalled memory (no ack) holds FETCH indefinitely; there is no timeout.

Optional Feature:
- Macro FCACHE_FILL_CRIT_FIRST_EN enables critical-word-first fetch.
- Defined:
  - start offset = req_addr[OFF_W-1:0]; fetch wraps modulo WORDS_PER_LINE.
  - On the first ack, crit_valid pulses one cycle (registered, cycle after ack) with crit_data = that word.
  - Final line contents are identical to the in-order fill.
- Undefined: start offset = 0, crit_valid and crit_data are tied 0, no extra logic.

Decomposition:
- fcache_pkg holds WORD_W, WORDS_PER_LINE, OFF_W, LINE_W, ADDR_W defaults and the state encodings IDLE=2'd0, FETCH=2'd1, COMMIT=2'd2.
- One sub-module: fcache_line_asm, the line buffer with indexed word insert, clear and write-enable. The top holds the FSM, counter and address generation.

Test Plan:
- Reset then idle → req_ready=1, all other outputs 0. Assert reset mid-FETCH at word 7 → fc_write never pulses, buffer 0, req_ready=1.
- req_addr=0x0023, zero-wait memory returning mem_rdata = 0x1000+k for word k:
  - mem_addr steps 0x0020..0x002F;
  - fc_write at cycle 17 with fc_addr=0x0002 and fc_wdata word k = 0x1000+k;
  - done coincident.
- Same fill with random 0–3 cycle ack delays → mem_addr stable while mem_rd=1 and unacked; identical fc_wdata.
- req_addr=0xFFF5 → mem_addr 0xFFF0..0xFFFF with no carry, fc_addr=0x0FFF. Second req_valid during fill is not accepted until cycle after COMMIT.
- Stray mem_ack in IDLE and in COMMIT → no state change, no buffer write.
- With FCACHE_FILL_CRIT_FIRST_EN, req_addr=0x002D:
  - mem_addr order 0x2D,0x2E,0x2F,0x20..0x2C;
  - crit_valid one pulse with crit_data = word 0xD data;
  - fc_wdata equals the in-order result.

Source files
------------

// File: rtl/fcache_pkg.sv
// Shared constants and state encoding for the fcache line-fill engine.
// Optional feature macro FCACHE_FILL_CRIT_FIRST_EN (critical-word-first) is consumed in
// fcache_fill.sv; nothing in this package depends on it.
package fcache_pkg;

   localparam int unsigned WORD_W         = 16;
   localparam int unsigned WORDS_PER_LINE = 16;
   localparam int unsigned OFF_W          = $clog2(WORDS_PER_LINE);
   localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
   localparam int unsigned ADDR_W         = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      COMMIT = 2'd2
   } fill_state_e;

   // Word address of word `off` within line `line_idx`; the line index carries only the
   // upper ADDR_W-OFF_W bits, so there is never a carry out of the address.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] line_idx,
                                                   input logic [OFF_W-1:0]  off);
      return {line_idx[ADDR_W-OFF_W-1:0], off};
   endfunction

endpackage

// File: rtl/fcache_line_asm.sv
// Line buffer for the fill engine: clears on a new fill and inserts one word at a time
// at an indexed word slot (slot 0 is the least significant word).
module fcache_line_asm
   import fcache_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              we_i,
   input  logic [OFF_W-1:0]  idx_i,
   input  logic [WORD_W-1:0] word_i,
   // Buffer contents including this cycle's insert, so the owner can capture a complete
   // line on the same edge that writes the final word.
   output logic [LINE_W-1:0] line_next_o
);

   logic [LINE_W-1:0] line_q, line_d;

   // Next buffer value: clear wins over insert.
   always_comb begin
      line_d = line_q;
      if (clr_i) begin
         line_d = '0;
      end else if (we_i) begin
         for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
            if (idx_i == OFF_W'(k)) begin
               line_d[k*WORD_W +: WORD_W] = word_i;
            end
         end
      end
   end

   // Buffer register; reset discards any partial line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign line_next_o = line_d;

endmodule

// File: rtl/fcache_fill.sv
// Line-fill engine upstream of fcache: on an accepted miss it reads one full line of words
// from memory over a valid/ack handshake, then writes the assembled line to fcache with a
// single-cycle write pulse. One fill in flight at a time.
// Optional feature: define FCACHE_FILL_CRIT_FIRST_EN for critical-word-first fetch order
// with a registered crit_valid/crit_data pulse on the first returned word.
module fcache_fill
   import fcache_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              fc_write,
   output logic [ADDR_W-1:0] fc_addr,
   output logic [LINE_W-1:0] fc_wdata,
   output logic              done,
   output logic              crit_valid,
   output logic [WORD_W-1:0] crit_data
);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] line_idx_q, line_idx_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] fc_addr_q, fc_addr_d;
   logic [LINE_W-1:0] fc_wdata_q, fc_wdata_d;

   logic              accept;
   logic              word_ack;
   logic              last_word;
   logic [OFF_W-1:0]  start_off;
   logic [LINE_W-1:0] line_next;

   assign accept    = req_valid && (state_q == IDLE);
   // Acks outside FETCH are stray and must not touch the buffer or counters.
   assign word_ack  = (state_q == FETCH) && mem_ack;
   assign last_word = word_ack && (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

`ifdef FCACHE_FILL_CRIT_FIRST_EN
   assign start_off = req_addr[OFF_W-1:0];
`else
   assign start_off = '0;
`endif

   fcache_line_asm u_line_asm (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (accept),
      .we_i        (word_ack),
      .idx_i       (off_q),
      .word_i      (mem_rdata),
      .line_next_o (line_next)
   );

   // Next-state, address generation and handshake outputs.
   always_comb begin
      state_d    = state_q;
      line_idx_d = line_idx_q;
      off_d      = off_q;
      cnt_d      = cnt_q;
      fc_addr_d  = fc_addr_q;
      fc_wdata_d = fc_wdata_q;
      req_ready  = 1'b0;
      mem_rd     = 1'b0;
      fc_write   = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d    = FETCH;
               line_idx_d = ADDR_W'(req_addr >> OFF_W);
               off_d      = start_off;
               cnt_d      = '0;
            end
         end
         FETCH: begin
            mem_rd = 1'b1;
            if (mem_ack) begin
               off_d = off_q + OFF_W'(1);
               cnt_d = cnt_q + OFF_W'(1);
               if (last_word) begin
                  // Capture the finished line now so fc_* hold steady through later fills.
                  state_d    = COMMIT;
                  fc_addr_d  = line_idx_q;
                  fc_wdata_d = line_next;
               end
            end
         end
         COMMIT: begin
            fc_write = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, address and commit registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         line_idx_q <= '0;
         off_q      <= '0;
         cnt_q      <= '0;
         fc_addr_q  <= '0;
         fc_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         line_idx_q <= line_idx_d;
         off_q      <= off_d;
         cnt_q      <= cnt_d;
         fc_addr_q  <= fc_addr_d;
         fc_wdata_q <= fc_wdata_d;
      end
   end

   // Address is forced to zero outside FETCH so an idle bus carries no stale line address.
   assign mem_addr = (state_q == FETCH) ? word_addr(line_idx_q, off_q) : '0;
   assign fc_addr  = fc_addr_q;
   assign fc_wdata = fc_wdata_q;
   assign done     = fc_write;

`ifdef FCACHE_FILL_CRIT_FIRST_EN
   logic              crit_valid_q;
   logic [WORD_W-1:0] crit_data_q;

   // Pulse the first returned word one cycle after its ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crit_valid_q <= 1'b0;
         crit_data_q  <= '0;
      end else begin
         crit_valid_q <= word_ack && (cnt_q == '0);
         if (word_ack && (cnt_q == '0)) begin
            crit_data_q <= mem_rdata;
         end
      end
   end

   assign crit_valid = crit_valid_q;
   assign crit_data  = crit_data_q;
`else
   assign crit_valid = 1'b0;
   assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_fcache_fill.sv
// Self-checking bench for fcache_fill: bench-driven memory responder, a transaction-level
// model of expected addresses/lines, and a per-cycle compare process.
module tb_fcache_fill;
   import fcache_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [WORD_W-1:0] mem_rdata;
   logic              fc_write;
   logic [ADDR_W-1:0] fc_addr;
   logic [LINE_W-1:0] fc_wdata;
   logic              done;
   logic              crit_valid;
   logic [WORD_W-1:0] crit_data;

   fcache_fill dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .fc_write   (fc_write),
      .fc_addr    (fc_addr),
      .fc_wdata   (fc_wdata),
      .done       (done),
      .crit_valid (crit_valid),
      .crit_data  (crit_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory contents: mode 0 gives 0x1000+k for word k of any line.
   int data_mode = 0;
   function automatic logic [WORD_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
      if (data_mode == 0) return 16'h1000 + {12'h000, a[3:0]};
      return a ^ 16'h5A3C;
   endfunction

   // Memory responder.
   bit rand_delay = 0;
   bit stray      = 0;
   int wait_left  = -1;
   always @(posedge clk) begin
      #1;
      mem_ack = 1'b0;
      if (reset) begin
         wait_left = -1;
      end else if (mem_rd) begin
         if (wait_left < 0) wait_left = rand_delay ? int'($urandom_range(0, 3)) : 0;
         if (wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_data(mem_addr);
            wait_left = -1;
         end else begin
            wait_left--;
         end
      end else begin
         wait_left = -1;
         if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hDEAD;
         end
      end
   end

   // Model state.
   bit                busy = 0, fetching = 0, committing = 0;
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [ADDR_W-1:0] obs_addr[$];
   logic [LINE_W-1:0] exp_line, held_line = '0;
   logic [ADDR_W-1:0] exp_fca, held_fca = '0;
   int                acks = 0, cyc = 0, fc_write_seen = 0, crit_pulses = 0;
   bit                zero_wait = 0;
   bit                prev_rd = 0, prev_acked = 0;
   logic [ADDR_W-1:0] prev_addr;
   bit                crit_due = 0;
   logic [WORD_W-1:0] crit_exp;

   // Compare process: checks every cycle, then advances the model to the next edge.
   always @(negedge clk) begin
      bit was_busy;
      if (reset) begin
         busy = 0; fetching = 0; committing = 0; acks = 0; crit_due = 0;
         held_line = '0; held_fca = '0; prev_rd = 0; prev_acked = 0;
         exp_addr_q.delete();
      end else begin
         cyc++;
         was_busy = busy;
         check("req_ready", req_ready, !busy);
         check("mem_rd", mem_rd, fetching);
         check("fc_write", fc_write, committing);
         check("done", done, fc_write);
         if (fc_write) fc_write_seen++;
         if (crit_valid) crit_pulses++;
         if (committing) begin
            check("fc_addr", fc_addr, exp_fca);
            check("fc_wdata", fc_wdata, exp_line);
            if (zero_wait) check("commit_cycle", cyc, 17);
         end else begin
            check("fc_addr_hold", fc_addr, held_fca);
            check("fc_wdata_hold", fc_wdata, held_line);
         end
         if (mem_rd && fetching) begin
            if (exp_addr_q.size() > 0) check("mem_addr", mem_addr, exp_addr_q[0]);
            if (prev_rd && !prev_acked) check("mem_addr_stable", mem_addr, prev_addr);
         end
`ifdef FCACHE_FILL_CRIT_FIRST_EN
         check("crit_valid", crit_valid, crit_due);
         if (crit_due) check("crit_data", crit_data, crit_exp);
`else
         check("crit_valid", crit_valid, 1'b0);
         check("crit_data", crit_data, 16'h0);
`endif
         crit_due   = 0;
         prev_rd    = mem_rd;
         prev_addr  = mem_addr;
         prev_acked = mem_rd && mem_ack;

         if (committing) begin
            committing = 0; busy = 0;
            held_line = exp_line; held_fca = exp_fca;
         end else if (fetching && mem_ack) begin
            if (acks == 0) begin
               crit_due = 1;
               crit_exp = mem_rdata;
            end
            obs_addr.push_back(mem_addr);
            if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
            acks++;
            if (acks == int'(WORDS_PER_LINE)) begin
               fetching = 0; committing = 1;
            end
         end

         if (!was_busy && req_valid) begin
            logic [ADDR_W-1:0] base, a;
            int start;
            busy = 1; fetching = 1; acks = 0; cyc = 0;
            base = req_addr & 16'hFFF0;
`ifdef FCACHE_FILL_CRIT_FIRST_EN
            start = int'(req_addr[3:0]);
`else
            start = 0;
`endif
            exp_addr_q.delete();
            exp_line = '0;
            for (int k = 0; k < 16; k++) begin
               a = base | ADDR_W'((start + k) % 16);
               exp_addr_q.push_back(a);
               exp_line[int'(a[3:0])*16 +: 16] = mem_data(a);
            end
            exp_fca = req_addr >> 4;
         end
      end
   end

   task automatic start_req(input logic [ADDR_W-1:0] addr);
      bit ok = 0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = addr;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL accept_timeout: got 0 expected 1"); end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_commit(input string tag);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (fc_write) begin ok = 1; break; end
      end
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL %s_timeout: got 0 expected 1", tag); end
   endtask

   logic [LINE_W-1:0] line0;
   int                seen_before;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_fc_write", fc_write, 1'b0);
      check("rst_fc_addr", fc_addr, 16'h0);
      check("rst_fc_wdata", fc_wdata, '0);
      check("rst_done", done, 1'b0);
      check("rst_crit_valid", crit_valid, 1'b0);
      check("rst_crit_data", crit_data, 16'h0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(negedge clk);

      // In-order zero-wait fill of line 0x0002.
      data_mode = 0; zero_wait = 1; obs_addr.delete();
      start_req(16'h0023);
      wait_commit("fill_0023");
      check("lit_fc_addr", fc_addr, 16'h0002);
      check("lit_word0", fc_wdata[15:0], 16'h1000);
      check("lit_word15", fc_wdata[255:240], 16'h100F);
      check("lit_done", done, 1'b1);
`ifdef FCACHE_FILL_CRIT_FIRST_EN
      check("lit_first_addr", obs_addr[0], 16'h0023);
      check("lit_last_addr", obs_addr[15], 16'h0022);
`else
      check("lit_first_addr", obs_addr[0], 16'h0020);
      check("lit_last_addr", obs_addr[15], 16'h002F);
`endif
      line0 = fc_wdata;
      zero_wait = 0;
      repeat (2) @(negedge clk);

      // Same fill with random ack delays.
      rand_delay = 1;
      start_req(16'h0023);
      wait_commit("fill_rand");
      check("rand_line", fc_wdata, line0);
      rand_delay = 0;
      repeat (2) @(negedge clk);

      // Address wrap at top of memory, with a second request held during the fill.
      data_mode = 1; zero_wait = 1; obs_addr.delete();
      start_req(16'hFFF5);
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 16'h1234;
      wait_commit("fill_fff5");
      check("busy_not_ready", req_ready, 1'b0);
      check("wrap_fc_addr", fc_addr, 16'h0FFF);
      check("wrap_word0", fc_wdata[15:0], 16'hA5CC);
      check("wrap_word15", fc_wdata[255:240], 16'hA5C3);
`ifdef FCACHE_FILL_CRIT_FIRST_EN
      check("wrap_first_addr", obs_addr[0], 16'hFFF5);
      check("wrap_last_addr", obs_addr[15], 16'hFFF4);
`else
      check("wrap_first_addr", obs_addr[0], 16'hFFF0);
      check("wrap_last_addr", obs_addr[15], 16'hFFFF);
`endif
      @(negedge clk);
      check("ready_after_commit", req_ready, 1'b1);
      @(posedge clk); #1 req_valid = 1'b0;
      wait_commit("fill_1234");
      check("second_fc_addr", fc_addr, 16'h0123);
      zero_wait = 0;
      repeat (2) @(negedge clk);

      // Stray acks in IDLE and COMMIT.
      data_mode = 0; stray = 1;
      seen_before = fc_write_seen;
      repeat (4) @(negedge clk);
      check("stray_idle_no_write", fc_write_seen, seen_before);
      start_req(16'h0023);
      wait_commit("fill_stray");
      repeat (3) @(negedge clk);
      check("stray_line", fc_wdata, line0);
      stray = 0;

      // Fill starting mid-line: critical word first when enabled.
      obs_addr.delete(); crit_pulses = 0;
      start_req(16'h002D);
      wait_commit("fill_002d");
      check("crit_line", fc_wdata, line0);
`ifdef FCACHE_FILL_CRIT_FIRST_EN
      check("crit_addr0", obs_addr[0], 16'h002D);
      check("crit_addr1", obs_addr[1], 16'h002E);
      check("crit_addr2", obs_addr[2], 16'h002F);
      check("crit_addr3", obs_addr[3], 16'h0020);
      check("crit_addr15", obs_addr[15], 16'h002C);
      check("crit_pulses", crit_pulses, 1);
`else
      check("crit_addr0", obs_addr[0], 16'h0020);
      check("crit_addr15", obs_addr[15], 16'h002F);
      check("crit_pulses", crit_pulses, 0);
`endif
      repeat (2) @(negedge clk);

      // Reset in the middle of FETCH.
      data_mode = 1;
      start_req(16'h4567);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (acks >= 7) break;
      end
      seen_before = fc_write_seen;
      @(posedge clk); #2 reset = 1'b1;
      @(negedge clk);
      check("abort_fc_write", fc_write, 1'b0);
      check("abort_mem_rd", mem_rd, 1'b0);
      check("abort_req_ready", req_ready, 1'b1);
      check("abort_fc_wdata", fc_wdata, '0);
      check("abort_buffer", dut.u_line_asm.line_q, '0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_no_commit", fc_write_seen, seen_before);
      check("abort_idle_ready", req_ready, 1'b1);

      // Recovery after abort.
      data_mode = 0;
      start_req(16'h0023);
      wait_commit("fill_recover");
      check("recover_line", fc_wdata, line0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
